// File: rtl/integ_model.sv
// integ_model: cycle-level integrator emulation with clamped accumulator,
// delayed threshold comparators, sticky fault flags and zero-crossing counter.
module integ_model #(
  parameter int ACC_W    = 24,
  parameter int VIN_W    = 16,
  parameter int REF_STEP = 1024,
  parameter int TH_MEDIA = 65536,
  parameter int TH_HIGH  = 262144,
  parameter int CMP_DLY  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VIN_W-1:0]   vin,
  input  logic               sw_in,
  input  logic               sw_refp,
  input  logic               sw_refn,
  input  logic               sw_clr,
  output logic               zeroLevel,
  output logic               mediaLevel,
  output logic               highLevel,
  output logic [ACC_W-1:0]   acc_out,
  output logic               sat,
  output logic               conflict,
  output logic [15:0]        zc_cnt
);
  localparam logic signed [ACC_W+1:0] REF  = (ACC_W+2)'(REF_STEP);
  localparam logic signed [ACC_W+1:0] ZERO = '0;
  localparam logic signed [ACC_W+1:0] MAXV = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W+1:0] MINV = {3'b111, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] TM   = ACC_W'(TH_MEDIA);
  localparam logic signed [ACC_W-1:0] TH   = ACC_W'(TH_HIGH);
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W+1:0] acc_x, vin_x, sum;
  logic                    sat_q, sat_d, conf_q, conf_d;
  logic [CMP_DLY-1:0]      z_q, m_q, h_q;
  logic [CMP_DLY:0]        z_d, m_d, h_d;
  logic [15:0]             zc_q, zc_d;
  // Two guard bits keep the worst-case sum exact before clamping.
  always_comb begin
    acc_x  = {{2{acc_q[ACC_W-1]}}, acc_q};
    vin_x  = {{(ACC_W+2-VIN_W){vin[VIN_W-1]}}, vin};
    sum    = acc_x + (sw_in ? vin_x : ZERO) + (sw_refn ? REF : ZERO) - (sw_refp ? REF : ZERO);
    acc_d  = sw_clr ? '0 : sum > MAXV ? MAXV[ACC_W-1:0] : sum < MINV ? MINV[ACC_W-1:0] : sum[ACC_W-1:0];
    sat_d  = !sw_clr && (sat_q || sum > MAXV || sum < MINV);
    conf_d = !sw_clr && (conf_q || (sw_refp && sw_refn));
    z_d    = {z_q, !acc_q[ACC_W-1]};
    m_d    = {m_q, acc_q >= TM};
    h_d    = {h_q, acc_q >= TH};
    zc_d   = zc_q + 16'(z_d[CMP_DLY-1] ^ z_q[CMP_DLY-1]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      sat_q  <= 1'b0;
      conf_q <= 1'b0;
      z_q    <= '1;
      m_q    <= '0;
      h_q    <= '0;
      zc_q   <= '0;
    end else begin
      acc_q  <= acc_d;
      sat_q  <= sat_d;
      conf_q <= conf_d;
      z_q    <= z_d[CMP_DLY-1:0];
      m_q    <= m_d[CMP_DLY-1:0];
      h_q    <= h_d[CMP_DLY-1:0];
      zc_q   <= zc_d;
    end
  end
  assign acc_out    = acc_q;
  assign sat        = sat_q;
  assign conflict   = conf_q;
  assign zeroLevel  = z_q[CMP_DLY-1];
  assign mediaLevel = m_q[CMP_DLY-1];
  assign highLevel  = h_q[CMP_DLY-1];
  assign zc_cnt     = zc_q;
endmodule

// File: tb/tb_integ_model.sv
// tb_integ_model: directed scenarios plus biased random stimulus checked every cycle
// against an integer reference model of the integrator.
module tb_integ_model;
  localparam int D = 2;
  localparam longint MAXA = 8388607, MINA = -8388608;
  localparam longint TMED = 65536, THI = 262144, REFS = 1024;
  logic clk = 1'b0, rst = 1'b0;
  logic [15:0] vin = '0;
  logic sw_in = 1'b0, sw_refp = 1'b0, sw_refn = 1'b0, sw_clr = 1'b0;
  logic zeroLevel, mediaLevel, highLevel, sat, conflict;
  logic [23:0] acc_out;
  logic [15:0] zc_cnt;
  int checks = 0, errors = 0;
  longint m_acc, m_out;
  longint q[$];
  bit m_sat, m_conf;
  int m_zc;

  integ_model dut (
    .clk(clk), .rst(rst), .vin(vin), .sw_in(sw_in), .sw_refp(sw_refp),
    .sw_refn(sw_refn), .sw_clr(sw_clr), .zeroLevel(zeroLevel),
    .mediaLevel(mediaLevel), .highLevel(highLevel), .acc_out(acc_out),
    .sat(sat), .conflict(conflict), .zc_cnt(zc_cnt)
  );

  always #5 clk = ~clk;

  // Comparator outputs after edge k reflect the accumulator after edge k-D.
  always @(posedge clk or posedge rst) begin
    longint s, old;
    if (rst) begin
      m_acc = 0; m_out = 0; m_sat = 0; m_conf = 0; m_zc = 0;
      q.delete();
      for (int i = 0; i < D; i++) q.push_back(0);
    end else begin
      if (sw_clr) begin
        s = 0; m_sat = 0; m_conf = 0;
      end else begin
        s = m_acc + (sw_in ? longint'($signed(vin)) : 0) + (sw_refn ? REFS : 0) - (sw_refp ? REFS : 0);
        if (s > MAXA) begin s = MAXA; m_sat = 1; end
        if (s < MINA) begin s = MINA; m_sat = 1; end
        if (sw_refp && sw_refn) m_conf = 1;
      end
      m_acc = s;
      old = q.pop_front();
      q.push_back(s);
      if ((old >= 0) != (m_out >= 0)) m_zc = (m_zc + 1) % 65536;
      m_out = old;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("acc", $signed(acc_out), m_acc);
    chk("zero", zeroLevel, m_out >= 0);
    chk("media", mediaLevel, m_out >= TMED);
    chk("high", highLevel, m_out >= THI);
    chk("sat", sat, m_sat);
    chk("conflict", conflict, m_conf);
    chk("zc_cnt", zc_cnt, m_zc);
    chk("order", (highLevel && !mediaLevel) || (mediaLevel && !zeroLevel), 0);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (!rst) compare_all();
    end
  endtask

  initial begin
    int v;
    bit up;
    #1 rst = 1'b1;
    #12 rst = 1'b0;
    tick(20);
    chk("idle_acc", $signed(acc_out), 0);
    chk("idle_zero", zeroLevel, 1);
    chk("idle_media", mediaLevel, 0);
    chk("idle_high", highLevel, 0);
    chk("idle_zc", zc_cnt, 0);
    sw_refn = 1'b1;
    tick(64);
    chk("ramp_acc64", $signed(acc_out), 65536);
    tick(1);
    chk("ramp_media65", mediaLevel, 0);
    tick(1);
    chk("ramp_media66", mediaLevel, 1);
    tick(191);
    chk("ramp_high257", highLevel, 0);
    tick(1);
    chk("ramp_high258", highLevel, 1);
    tick(42);
    chk("ramp_acc300", $signed(acc_out), 307200);
    sw_refn = 1'b0; sw_clr = 1'b1;
    tick(1);
    chk("clr_acc", $signed(acc_out), 0);
    sw_clr = 1'b0;
    tick(3);
    sw_in = 1'b1; vin = 16'hFC18;
    tick(2);
    chk("neg_zero_e1", zeroLevel, 1);
    tick(1);
    chk("neg_zero_e2", zeroLevel, 0);
    tick(7);
    chk("neg_acc", $signed(acc_out), -10000);
    chk("neg_zc", zc_cnt, 1);
    sw_in = 1'b0; sw_clr = 1'b1;
    tick(1);
    sw_clr = 1'b0; sw_refn = 1'b1;
    tick(8191);
    sw_refn = 1'b0; sw_in = 1'b1; vin = 16'd416;
    tick(1);
    chk("pre_sat_acc", $signed(acc_out), 8388000);
    sw_in = 1'b0; sw_refn = 1'b1;
    tick(1);
    chk("sat_acc", $signed(acc_out), 8388607);
    chk("sat_flag", sat, 1);
    tick(5);
    chk("sat_hold", $signed(acc_out), 8388607);
    sw_refn = 1'b0; sw_clr = 1'b1;
    tick(1);
    chk("sat_clr_acc", $signed(acc_out), 0);
    chk("sat_clr_flag", sat, 0);
    sw_clr = 1'b0; sw_in = 1'b1; vin = 16'd1234;
    tick(1);
    sw_in = 1'b0; sw_refp = 1'b1; sw_refn = 1'b1;
    tick(5);
    chk("conf_acc", $signed(acc_out), 1234);
    chk("conf_flag", conflict, 1);
    sw_refp = 1'b0; sw_refn = 1'b0;
    tick(4);
    chk("conf_hold", conflict, 1);
    sw_clr = 1'b1;
    tick(1);
    chk("conf_clr", conflict, 0);
    sw_clr = 1'b0; sw_refn = 1'b1;
    tick(100);
    chk("pre_rst_media", mediaLevel, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_acc", $signed(acc_out), 0);
    chk("arst_zero", zeroLevel, 1);
    chk("arst_media", mediaLevel, 0);
    chk("arst_high", highLevel, 0);
    chk("arst_zc", zc_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(3);
    chk("restart_acc", $signed(acc_out), 3072);
    up = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 800 == 0) up = !up;
      sw_clr = ($urandom_range(0, 499) == 0);
      sw_in = $urandom_range(0, 1);
      v = int'($urandom_range(0, 32767));
      v = up ? v : -v - 1;
      vin = v[15:0];
      sw_refn = up ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      sw_refp = up ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/integ_model.md
INTEG_MODEL -- requirements
Module: integ_model

Interface
- REQ-001 SHALL have parameter ACC_W, default 24, meaning accumulator width in bits, signed two's complement.
- REQ-002 SHALL have parameter VIN_W, default 16, meaning emulated input sample width in bits, signed.
- REQ-003 SHALL have parameter REF_STEP, default 1024, meaning per-cycle reference current magnitude in LSB.
- REQ-004 SHALL have parameter TH_MEDIA, default 65536, meaning media comparator threshold, with 0 < TH_MEDIA < TH_HIGH.
- REQ-005 SHALL have parameter TH_HIGH, default 262144, meaning high comparator threshold.
- REQ-006 SHALL have parameter CMP_DLY, default 2, range 1..8, meaning comparator output latency in cycles.
- REQ-007 SHALL have port clk, input, width 1, the single clock; all state changes on its rising edge.
- REQ-008 SHALL have port rst, input, width 1, asynchronous active-high reset.
- REQ-009 SHALL have port vin, input, width VIN_W, signed emulated input value.
- REQ-010 SHALL have port sw_in, input, width 1, input switch closed.
- REQ-011 SHALL have port sw_refp, input, width 1, positive reference switch closed (discharges).
- REQ-012 SHALL have port sw_refn, input, width 1, negative reference switch closed (charges).
- REQ-013 SHALL have port sw_clr, input, width 1, integrator short or discharge request.
- REQ-014 SHALL have ports zeroLevel, mediaLevel and highLevel, each output, width 1, comparator outputs.
- REQ-015 SHALL have port acc_out, output, width ACC_W, current accumulator value with no delay.
- REQ-016 SHALL have port sat, output, width 1, sticky saturation flag.
- REQ-017 SHALL have port conflict, output, width 1, sticky flag set when both reference switches are closed.
- REQ-018 SHALL have port zc_cnt, output, width 16, count of zeroLevel transitions.

Function
- REQ-019 SHALL update every cycle when sw_clr=0: acc_next = acc + (sw_in ? sext(vin) : 0) + (sw_refn ? REF_STEP : 0) - (sw_refp ? REF_STEP : 0).
- REQ-020 SHALL compute the sum at ACC_W+2 bits.
- REQ-021 SHALL clamp the sum to [-2^(ACC_W-1), 2^(ACC_W-1)-1] when it falls outside that range, and set sat=1 in the same cycle the clamp is applied.
- REQ-022 SHALL, when sw_clr=1, load acc=0 on the next edge, clear sat and conflict, and ignore all other switches for that cycle.
- REQ-023 SHALL, when sw_refp=1 and sw_refn=1 together with sw_clr=0, let both terms apply (net zero) and set conflict=1.
- REQ-024 SHALL keep sat and conflict set until sw_clr or rst.
- REQ-025 SHALL compute the raw comparators from acc each cycle: zero_raw = (acc >= 0); media_raw = (acc >= TH_MEDIA); high_raw = (acc >= TH_HIGH).
- REQ-026 SHALL delay the raw comparators through a CMP_DLY-stage shift pipeline, so an acc change on edge N appears on the outputs on edge N+CMP_DLY.
- REQ-027 SHALL hold the invariant highLevel=1 implies mediaLevel=1 implies zeroLevel=1 at all times.
- REQ-028 SHALL increment zc_cnt by 1 on each cycle where the delayed zeroLevel differs from its previous value.
- REQ-029 SHALL wrap zc_cnt from 0xFFFF to 0x0000 without a flag.
- REQ-030 SHALL leave zc_cnt uncleared by sw_clr.
- REQ-031 SHALL have no state machine beyond the accumulator, pipeline, flags and counter.
- REQ-032 SHALL keep the block fully synthesizable, usable as an FPGA loopback target for the converter controller.

Reset
- REQ-033 SHALL, on rst=1 and independent of clk, set acc=0, every pipeline stage to (zero=1, media=0, high=0), sat=0, conflict=0 and zc_cnt=0.
- REQ-034 SHALL make outputs zeroLevel=1, mediaLevel=0, highLevel=0 and acc_out=0 while rst=1.
- REQ-035 SHALL, when rst is asserted mid-integration, discard all accumulated charge and any pending pipeline values.
- REQ-036 SHALL resume integration on the first rising edge after rst deasserts.

Verification
- REQ-037 SHALL cover: rst pulse, then idle switches for 20 cycles -> acc_out=0, zero=1, media=0, high=0, zc_cnt=0.
- REQ-038 SHALL cover: sw_refn=1 for 300 cycles from 0 -> acc=307200; mediaLevel rises 2 cycles after acc reaches 65536 (cycle 64); highLevel rises 2 cycles after cycle 256.
- REQ-039 SHALL cover: sw_in=1 with vin=-1000 for 10 cycles from acc=0 -> acc=-10000; zeroLevel falls exactly CMP_DLY cycles after the first update; zc_cnt=1.
- REQ-040 SHALL cover: sw_refn=1 held from acc=8388000 -> acc clamps at 8388607 and sat=1; a following sw_clr pulse -> acc=0 and sat=0.
- REQ-041 SHALL cover: sw_refp=1 and sw_refn=1 for 5 cycles -> acc unchanged and conflict=1, with conflict held until sw_clr.
- REQ-042 SHALL cover: rst asserted between edges during ramp -> all outputs reach reset values without waiting for a clock edge; integration restarts from 0 after release.
